// File: rtl/imm_gen_if.sv
// imm_gen_if: valid/ready bundle between decode, the immediate generator and execute.
//   in_valid/in_ready/in_instr/in_extop/in_tag : instruction side
//   out_valid/out_ready/out_imm/out_tag/out_bad : immediate side
//   master = producer of instructions and consumer of immediates, slave = imm_gen_pipe
interface imm_gen_if #(
   parameter int XLEN  = 64,
   parameter int TAG_W = 8
) ();
   logic             in_valid;
   logic             in_ready;
   logic [31:0]      in_instr;
   logic [2:0]       in_extop;
   logic [TAG_W-1:0] in_tag;
   logic             out_valid;
   logic             out_ready;
   logic [XLEN-1:0]  out_imm;
   logic [TAG_W-1:0] out_tag;
   logic             out_bad;
   modport master (
      output in_valid, in_instr, in_extop, in_tag, out_ready,
      input  in_ready, out_valid, out_imm, out_tag, out_bad
   );
   modport slave (
      input  in_valid, in_instr, in_extop, in_tag, out_ready,
      output in_ready, out_valid, out_imm, out_tag, out_bad
   );
endinterface

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: registered RV immediate generator behind a 2-entry skid buffer.
//   clk, rst (sync, active-high), flush (drops all held entries)
//   bus.slave : in_* instruction handshake, out_* immediate handshake, out_bad for illegal shamt
module imm_gen_pipe #(
   parameter int XLEN  = 64,
   parameter int TAG_W = 8
) (
   input logic        clk,
   input logic        rst,
   input logic        flush,
   imm_gen_if.slave   bus
);
   if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
      $error("imm_gen_pipe: XLEN must be 32 or 64");
   end
   logic             or_v, sr_v;
   logic [31:0]      or_i, sr_i;
   logic [2:0]       or_e, sr_e;
   logic [TAG_W-1:0] or_t, sr_t;
   logic             acc, load;
   logic [XLEN-1:0]  imm;
   logic             unused;
   // in_ready comes straight from the skid flag, so out_ready never reaches it combinationally
   assign acc    = bus.in_valid && !sr_v;
   assign load   = !or_v || bus.out_ready;
   assign unused = ^or_i[6:0];
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         or_v <= 1'b0;
         sr_v <= 1'b0;
      end else if (load) begin
         or_v <= sr_v || acc;
         sr_v <= 1'b0;
      end else if (acc) begin
         sr_v <= 1'b1;
      end
      if (rst) begin
         or_i <= '0;
         or_e <= '0;
         or_t <= '0;
      end else if (!flush && load && sr_v) begin
         or_i <= sr_i;
         or_e <= sr_e;
         or_t <= sr_t;
      end else if (!flush && load && acc) begin
         or_i <= bus.in_instr;
         or_e <= bus.in_extop;
         or_t <= bus.in_tag;
      end
      if (!rst && !flush && !load && acc) begin
         sr_i <= bus.in_instr;
         sr_e <= bus.in_extop;
         sr_t <= bus.in_tag;
      end
   end
   // Decoded from the captured word so the output only changes when the output register loads
   always_comb begin
      imm = or_e == 3'd0 ? XLEN'($signed(or_i[31:20])) :
            or_e == 3'd1 ? XLEN'($signed({or_i[31:12], 12'b0})) :
            or_e == 3'd2 ? XLEN'($signed({or_i[31:25], or_i[11:7]})) :
            or_e == 3'd3 ? XLEN'($signed({or_i[31], or_i[7], or_i[30:25], or_i[11:8], 1'b0})) :
            or_e == 3'd4 ? XLEN'($signed({or_i[31], or_i[19:12], or_i[20], or_i[30:21], 1'b0})) :
            or_e == 3'd5 ? (XLEN == 64 ? XLEN'(or_i[25:20]) : XLEN'(or_i[24:20])) :
            or_e == 3'd6 ? XLEN'(or_i[19:15]) : '0;
   end
   assign bus.in_ready  = !sr_v;
   assign bus.out_valid = or_v;
   assign bus.out_imm   = imm;
   assign bus.out_tag   = or_t;
   assign bus.out_bad   = or_e == 3'd5 && XLEN == 32 && or_i[25];
endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb_imm_gen_pipe: directed checks of imm_gen_pipe at XLEN=64 and XLEN=32 driven in lockstep.
module tb_imm_gen_pipe;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        flush = 1'b0;
   logic        v = 1'b0;
   logic [31:0] instr = '0;
   logic [2:0]  extop = '0;
   logic [7:0]  tag = '0;
   logic        ordy = 1'b1;
   int          total = 0;
   int          passed = 0;
   imm_gen_if #(.XLEN(64), .TAG_W(8)) b64 ();
   imm_gen_if #(.XLEN(32), .TAG_W(8)) b32 ();
   assign b64.in_valid = v;
   assign b64.in_instr = instr;
   assign b64.in_extop = extop;
   assign b64.in_tag = tag;
   assign b64.out_ready = ordy;
   assign b32.in_valid = v;
   assign b32.in_instr = instr;
   assign b32.in_extop = extop;
   assign b32.in_tag = tag;
   assign b32.out_ready = ordy;
   imm_gen_pipe #(.XLEN(64), .TAG_W(8)) dut64 (.clk(clk), .rst(rst), .flush(flush), .bus(b64));
   imm_gen_pipe #(.XLEN(32), .TAG_W(8)) dut32 (.clk(clk), .rst(rst), .flush(flush), .bus(b32));
   always #5 clk = ~clk;
   task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%h expected=%h", name, obs, exp);
   endtask
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   task automatic send(input logic [31:0] i, input logic [2:0] e, input logic [7:0] t);
      v = 1'b1;
      instr = i;
      extop = e;
      tag = t;
      step();
      v = 1'b0;
   endtask
   initial begin
      step();
      step();
      rst = 1'b0;
      step();
      chk("rst_valid", 64'(b64.out_valid), 64'd0);
      chk("rst_imm", b64.out_imm, 64'd0);
      chk("rst_tag", 64'(b64.out_tag), 64'd0);
      chk("rst_bad", 64'(b64.out_bad), 64'd0);
      chk("rst_ready", 64'(b64.in_ready), 64'd1);
      send(32'hFE000EE3, 3'd3, 8'd1);
      chk("b_valid", 64'(b64.out_valid), 64'd1);
      chk("b_imm64", b64.out_imm, 64'hFFFFFFFFFFFFFFFC);
      chk("b_imm32", 64'(b32.out_imm), 64'hFFFFFFFC);
      chk("b_bad", 64'(b64.out_bad), 64'd0);
      send(32'h43F0D093, 3'd5, 8'd2);
      chk("sh_imm64", b64.out_imm, 64'h3F);
      chk("sh_bad64", 64'(b64.out_bad), 64'd0);
      chk("sh_imm32", 64'(b32.out_imm), 64'h1F);
      chk("sh_bad32", 64'(b32.out_bad), 64'd1);
      send(32'h40F0D093, 3'd5, 8'd3);
      chk("sh15_imm64", b64.out_imm, 64'd15);
      chk("sh15_imm32", 64'(b32.out_imm), 64'd15);
      chk("sh15_bad32", 64'(b32.out_bad), 64'd0);
      send(32'h800000B7, 3'd1, 8'd4);
      chk("u_imm32", 64'(b32.out_imm), 64'h80000000);
      chk("u_imm64", b64.out_imm, 64'hFFFFFFFF80000000);
      send(32'hFFF00093, 3'd0, 8'd5);
      chk("i_imm64", b64.out_imm, 64'hFFFFFFFFFFFFFFFF);
      send(32'hFE112E23, 3'd2, 8'd6);
      chk("s_imm64", b64.out_imm, 64'hFFFFFFFFFFFFFFFC);
      send(32'hFFDFF06F, 3'd4, 8'd7);
      chk("j_imm64", b64.out_imm, 64'hFFFFFFFFFFFFFFFC);
      chk("j_tag", 64'(b64.out_tag), 64'd7);
      send(32'h3401D073, 3'd6, 8'd8);
      chk("csr_imm64", b64.out_imm, 64'd3);
      send(32'hFFFFFFFF, 3'd7, 8'd9);
      chk("none_imm64", b64.out_imm, 64'd0);
      chk("none_bad32", 64'(b32.out_bad), 64'd0);
      step();
      chk("idle_valid", 64'(b64.out_valid), 64'd0);
      ordy = 1'b0;
      send(32'h00100013, 3'd0, 8'd1);
      chk("bp1_tag", 64'(b64.out_tag), 64'd1);
      chk("bp1_ready", 64'(b64.in_ready), 64'd1);
      send(32'h00200013, 3'd0, 8'd2);
      chk("bp2_ready", 64'(b64.in_ready), 64'd0);
      chk("bp2_tag", 64'(b64.out_tag), 64'd1);
      v = 1'b1;
      instr = 32'h00300013;
      extop = 3'd0;
      tag = 8'd3;
      step();
      chk("bp3_hold_tag", 64'(b64.out_tag), 64'd1);
      chk("bp3_hold_imm", b64.out_imm, 64'd1);
      chk("bp3_ready", 64'(b64.in_ready), 64'd0);
      ordy = 1'b1;
      step();
      chk("bp_out2_tag", 64'(b64.out_tag), 64'd2);
      chk("bp_out2_imm", b64.out_imm, 64'd2);
      chk("bp_out2_ready", 64'(b64.in_ready), 64'd1);
      step();
      v = 1'b0;
      chk("bp_out3_tag", 64'(b64.out_tag), 64'd3);
      chk("bp_out3_valid", 64'(b64.out_valid), 64'd1);
      step();
      chk("bp_drained", 64'(b64.out_valid), 64'd0);
      ordy = 1'b0;
      send(32'h00400013, 3'd0, 8'd4);
      send(32'h00500013, 3'd0, 8'd5);
      chk("fl_full", 64'(b64.in_ready), 64'd0);
      v = 1'b1;
      tag = 8'd6;
      flush = 1'b1;
      step();
      flush = 1'b0;
      v = 1'b0;
      chk("fl_valid", 64'(b64.out_valid), 64'd0);
      chk("fl_ready", 64'(b64.in_ready), 64'd1);
      ordy = 1'b1;
      step();
      chk("fl_valid2", 64'(b64.out_valid), 64'd0);
      ordy = 1'b0;
      send(32'h00700013, 3'd0, 8'd7);
      chk("fl2_pre", 64'(b64.out_tag), 64'd7);
      v = 1'b1;
      tag = 8'd8;
      flush = 1'b1;
      step();
      flush = 1'b0;
      v = 1'b0;
      ordy = 1'b1;
      chk("fl2_valid", 64'(b64.out_valid), 64'd0);
      step();
      chk("fl2_valid2", 64'(b64.out_valid), 64'd0);
      ordy = 1'b0;
      send(32'h00900013, 3'd0, 8'd9);
      chk("rs_pre_valid", 64'(b64.out_valid), 64'd1);
      rst = 1'b1;
      ordy = 1'b1;
      step();
      rst = 1'b0;
      chk("rs_valid", 64'(b64.out_valid), 64'd0);
      chk("rs_imm", b64.out_imm, 64'd0);
      chk("rs_tag", 64'(b64.out_tag), 64'd0);
      chk("rs_ready", 64'(b64.in_ready), 64'd1);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
